// File: rtl/guess_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : guess_pkg                                                      |
// | Brief    : Shared types and 7-segment constants for the guess display.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package guess_pkg;

    localparam int WIDTH_GUESS = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HINT = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } state_e;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_DIGIT [0:5] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D};
    localparam logic [6:0] SEG_L     = 7'h38;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_ALL   = 7'h7F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] digit_to_seg(input logic [2:0] digit);
        logic [6:0] seg;
        case (digit)
            3'd0:    seg = SEG_DIGIT[0];
            3'd1:    seg = SEG_DIGIT[1];
            3'd2:    seg = SEG_DIGIT[2];
            3'd3:    seg = SEG_DIGIT[3];
            3'd4:    seg = SEG_DIGIT[4];
            3'd5:    seg = SEG_DIGIT[5];
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage : guess_pkg
`default_nettype wire

// File: rtl/guess_popcount6.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : guess_popcount6                                                |
// | Brief    : Counts set bits of the checker match vector (0..6).           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module guess_popcount6
    import guess_pkg::*;
(
    input  logic [WIDTH_GUESS-1:0] bits,
    output logic [2:0]             count
);

    always_comb begin
        count = 3'd0;
        for (int i = 0; i < WIDTH_GUESS; i++) begin
            count = count + {2'b00, bits[i]};
        end
    end

endmodule : guess_popcount6
`default_nettype wire

// File: rtl/guess_result_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : guess_result_display                                          |
// | Brief    : Turns checker results into a timed hint digit, win blink or   |
// |            lose glyph on a registered 7-segment display.                 |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module guess_result_display
    import guess_pkg::*;
#(
    parameter int HOLD_CYCLES = 1024,
    parameter int BLINK_HALF  = 256,
    parameter int WIN_BLINKS  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   result_valid,
    input  logic [WIDTH_GUESS-1:0] result,
    input  logic                   lose,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic                   busy
);

    localparam int TIMER_MAX = (HOLD_CYCLES > BLINK_HALF) ? HOLD_CYCLES : BLINK_HALF;
    localparam int TW        = $clog2(TIMER_MAX + 1);
    localparam int BW        = $clog2(WIN_BLINKS + 1);

    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(BLINK_HALF - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(WIN_BLINKS - 1);

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [BW-1:0]   blink_q, blink_d;
    logic            phase_q, phase_d;
    logic [2:0]      digit_q, digit_d;
    logic [6:0]      seg_q,   seg_d;
    logic            dp_q,    dp_d;
    logic            busy_q,  busy_d;

    logic [2:0]      pop_count;
    logic            accept;
    state_e          class_state;

    guess_popcount6 u_popcount (
        .bits  (result),
        .count (pop_count)
    );

    // The win animation is never interrupted; every other state takes a strobe.
    assign accept = result_valid && (state_q != WIN);

    always_comb begin
        if (lose) begin
            class_state = LOSE;
        end else if (pop_count == 3'd6) begin
            class_state = WIN;
        end else begin
            class_state = HINT;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            blink_q <= '0;
            phase_q <= 1'b0;
            digit_q <= 3'd0;
            seg_q   <= SEG_DASH;
            dp_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        blink_d = blink_q;
        phase_d = phase_q;
        digit_d = digit_q;

        case (state_q)
            IDLE, HINT, LOSE: begin
                if (accept) begin
                    // A strobe on the expiry edge takes priority over returning to IDLE.
                    state_d = class_state;
                    timer_d = '0;
                    blink_d = '0;
                    phase_d = 1'b1;
                    digit_d = pop_count;
                end else if (state_q != IDLE) begin
                    if (timer_q == HOLD_LAST) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            WIN: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    phase_d = ~phase_q;
                    // A full period ends at the close of each off phase.
                    if (!phase_q) begin
                        if (blink_q == BLINK_LAST) begin
                            state_d = IDLE;
                            blink_d = '0;
                        end else begin
                            blink_d = blink_q + 1'b1;
                        end
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                blink_d = '0;
                phase_d = 1'b0;
            end
        endcase
    end

    // Output logic, decoded from the next state so the pins register alongside it
    always_comb begin
        seg_d  = SEG_DASH;
        dp_d   = 1'b0;
        busy_d = (state_d != IDLE);
        case (state_d)
            IDLE: seg_d = SEG_DASH;
            HINT: seg_d = digit_to_seg(digit_d);
            LOSE: seg_d = SEG_L;
            WIN: begin
                seg_d = phase_d ? SEG_ALL : SEG_BLANK;
                dp_d  = phase_d;
            end
            default: seg_d = SEG_DASH;
        endcase
    end

    assign seg  = seg_q;
    assign dp   = dp_q;
    assign busy = busy_q;

endmodule : guess_result_display
`default_nettype wire

// File: tb/tb_guess_result_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_guess_result_display                                       |
// | Brief    : Directed self-checking bench for guess_result_display.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_guess_result_display;

    localparam int HOLD  = 1024;
    localparam int HALF  = 256;
    localparam int BLNK  = 4;
    localparam int WIN_LEN = 2 * HALF * BLNK;
    localparam int LIMIT = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       result_valid = 1'b0;
    logic [5:0] result = 6'h00;
    logic       lose = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    int vectors    = 0;
    int miscompares = 0;

    guess_result_display #(
        .HOLD_CYCLES (HOLD),
        .BLINK_HALF  (HALF),
        .WIN_BLINKS  (BLNK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .result_valid (result_valid),
        .result       (result),
        .lose         (lose),
        .seg          (seg),
        .dp           (dp),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle strobe; afterwards leaves junk on result/lose that must be ignored.
    task automatic strobe(input logic [5:0] r, input logic l);
        result_valid = 1'b1;
        result       = r;
        lose         = l;
        tick();
        result_valid = 1'b0;
        result       = 6'h3F;
        lose         = 1'b1;
    endtask

    task automatic hold_run(input logic [6:0] exp_seg, output int n, output int bad);
        n   = 0;
        bad = 0;
        while (busy === 1'b1 && n < LIMIT) begin
            if (seg !== exp_seg || dp !== 1'b0) bad++;
            n++;
            tick();
        end
    endtask

    task automatic win_run(input int start, output int end_idx, output int bad);
        int  i;
        logic on;
        i   = start;
        bad = 0;
        while (busy === 1'b1 && i < LIMIT) begin
            on = (((i / HALF) % 2) == 0);
            if (seg !== (on ? 7'h7F : 7'h00) || dp !== on) bad++;
            i++;
            tick();
        end
        end_idx = i;
    endtask

    task automatic chk_idle(input string tag);
        chk7({tag, "_seg"}, seg, 7'h40);
        chk1({tag, "_dp"}, dp, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int n;
        int bad;

        // Reset and idle
        #2 rst = 1'b0;
        #1;
        chk_idle("reset");
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_idle("idle");
        end

        // Inputs without result_valid are ignored
        result = 6'h3F;
        lose   = 1'b1;
        repeat (3) tick();
        chk_idle("novalid");

        // Three matching bits show digit three
        strobe(6'b101001, 1'b0);
        chk7("hint3_seg", seg, 7'h4F);
        chk1("hint3_busy", busy, 1'b1);
        hold_run(7'h4F, n, bad);
        chk_int("hint3_len", n, HOLD);
        chk_int("hint3_bad", bad, 0);
        chk_idle("hint3_end");

        // Win animation
        strobe(6'b111111, 1'b0);
        chk7("win_seg0", seg, 7'h7F);
        chk1("win_dp0", dp, 1'b1);
        win_run(0, n, bad);
        chk_int("win_len", n, WIN_LEN);
        chk_int("win_bad", bad, 0);
        chk_idle("win_end");

        // Lose overrides a full match
        strobe(6'b111111, 1'b1);
        chk7("lose_seg", seg, 7'h38);
        chk1("lose_dp", dp, 1'b0);
        hold_run(7'h38, n, bad);
        chk_int("lose_len", n, HOLD);
        chk_int("lose_bad", bad, 0);
        chk_idle("lose_end");

        // Pre-empting a hint restarts the timer
        strobe(6'b000011, 1'b0);
        chk7("hint2_seg", seg, 7'h5B);
        repeat (99) tick();
        chk7("hint2_seg99", seg, 7'h5B);
        strobe(6'b000000, 1'b0);
        chk7("hint0_seg", seg, 7'h3F);
        hold_run(7'h3F, n, bad);
        chk_int("hint0_len", n, HOLD);
        chk_int("hint0_bad", bad, 0);
        chk_idle("hint0_end");

        // Strobe during win is dropped
        strobe(6'b111111, 1'b0);
        repeat (300) tick();
        result_valid = 1'b1;
        result       = 6'b000001;
        lose         = 1'b0;
        tick();
        result_valid = 1'b0;
        chk7("win_drop_seg", seg, 7'h00);
        win_run(301, n, bad);
        chk_int("win_drop_len", n, WIN_LEN);
        chk_int("win_drop_bad", bad, 0);
        chk_idle("win_drop_end");

        // Strobe on the exact expiry edge
        strobe(6'b000001, 1'b0);
        chk7("hint1_seg", seg, 7'h06);
        repeat (HOLD - 1) tick();
        chk7("hint1_last_seg", seg, 7'h06);
        chk1("hint1_last_busy", busy, 1'b1);
        strobe(6'b011111, 1'b0);
        chk7("hint5_seg", seg, 7'h6D);
        chk1("hint5_busy", busy, 1'b1);
        hold_run(7'h6D, n, bad);
        chk_int("hint5_len", n, HOLD);
        chk_idle("hint5_end");

        // Asynchronous reset mid-win
        strobe(6'b111111, 1'b0);
        repeat (10) tick();
        chk7("win_pre_rst_seg", seg, 7'h7F);
        #2 rst = 1'b0;
        #1;
        chk_idle("async_rst");
        #1 rst = 1'b1;
        tick();
        chk_idle("after_rst");
        tick();
        chk_idle("after_rst2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_guess_result_display
`default_nettype wire
